// File: rtl/io_access_arbiter_pkg.sv
// Shared constants, FSM state type and access decoder for the IO access arbiter.
package io_access_arbiter_pkg;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned SUB_W_DEF  = 2;

   localparam logic [1:0] DEV_LED    = 2'd0;
   localparam logic [1:0] DEV_SWITCH = 2'd1;
   localparam logic [1:0] DEV_TUBE   = 2'd2;
   localparam logic [1:0] DEV_NONE   = 2'd3;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   // Returns {tube, switch, led}; all-zero marks an illegal access.
   function automatic logic [2:0] decode_strobes(input logic we, input logic [1:0] dev);
      if (we && dev == DEV_LED)     return 3'b001;
      if (!we && dev == DEV_SWITCH) return 3'b010;
      if (we && dev == DEV_TUBE)    return 3'b100;
      return 3'b000;
   endfunction
endpackage

// File: rtl/io_access_arbiter_if.sv
// Requester-side bus of the IO access arbiter: requests in, grant/completion/read data out.
interface io_access_arbiter_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned SUB_W  = 2
);
   logic [1:0]        iReq;
   logic [1:0]        iWe;
   logic [SUB_W+1:0]  iAddr0;
   logic [SUB_W+1:0]  iAddr1;
   logic [DATA_W-1:0] iWdata0;
   logic [DATA_W-1:0] iWdata1;
   logic [1:0]        oGnt;
   logic [1:0]        oDone;
   logic              oErr;
   logic [DATA_W-1:0] oRdata;

   modport master (
      output iReq, iWe, iAddr0, iAddr1, iWdata0, iWdata1,
      input  oGnt, oDone, oErr, oRdata
   );

   modport slave (
      input  iReq, iWe, iAddr0, iAddr1, iWdata0, iWdata1,
      output oGnt, oDone, oErr, oRdata
   );
endinterface

// File: rtl/io_access_arbiter_rr_arbiter2.sv
// Two-input picker: round-robin (ARB_MODE=0) or fixed CPU priority (ARB_MODE=1).
module io_access_arbiter_rr_arbiter2 #(
   parameter int unsigned ARB_MODE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic last_q, last_d;

   // last_q=1 means debug was granted last, so the CPU wins the next tie.
   always_comb begin
      if (req == 2'b11) begin
         gnt = (ARB_MODE == 1 || last_q) ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
      last_d = last_q;
      if (advance && (|req)) begin
         last_d = gnt[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
endmodule

// File: rtl/io_access_arbiter.sv
// Shares the LED, switch and tube drivers between the CPU (req 0) and debug monitor (req 1),
// sequencing one IDLE -> ACCESS -> DONE transaction at a time.
module io_access_arbiter
   import io_access_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned SUB_W    = SUB_W_DEF,
   parameter int unsigned ARB_MODE = 0
) (
   input  logic               iCpuClock,
   input  logic               iCpuReset,
   io_access_arbiter_if.slave bus,
   output logic               oDoLedWrite,
   output logic [SUB_W-1:0]   oLightAddress,
   output logic [DATA_W-1:0]  oLightData,
   output logic               oDoSwitchRead,
   output logic [SUB_W-1:0]   oSwitchAddress,
   input  logic [DATA_W-1:0]  iSwitchData,
   output logic               oDoTubeWrite,
   output logic [SUB_W-1:0]   oTubeAddress,
   output logic [DATA_W-1:0]  oTubeData
);
   state_e            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic [1:0]        dev_q, dev_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [SUB_W-1:0]  sub_q, sub_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [2:0]        strobe_q, strobe_d;
   logic [1:0]        arb_gnt;
   logic [SUB_W+1:0]  win_addr;
   logic              win_we;

   io_access_arbiter_rr_arbiter2 #(.ARB_MODE(ARB_MODE)) u_arb (
      .clk     (iCpuClock),
      .rst     (iCpuReset),
      .req     (bus.iReq),
      .advance (state_q == IDLE),
      .gnt     (arb_gnt)
   );

   assign win_addr = arb_gnt[1] ? bus.iAddr1 : bus.iAddr0;
   assign win_we   = bus.iWe[arb_gnt[1]];

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      dev_d    = dev_q;
      sub_d    = sub_q;
      wdata_d  = wdata_q;
      gnt_d    = '0;
      strobe_d = '0;
      done_d   = '0;
      err_d    = 1'b0;
      rdata_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (|bus.iReq) begin
               state_d  = ACCESS;
               gnt_d    = arb_gnt;
               owner_d  = arb_gnt[1];
               we_d     = win_we;
               dev_d    = win_addr[SUB_W+1:SUB_W];
               sub_d    = win_addr[SUB_W-1:0];
               wdata_d  = arb_gnt[1] ? bus.iWdata1 : bus.iWdata0;
               strobe_d = decode_strobes(win_we, win_addr[SUB_W+1:SUB_W]);
            end
         end
         ACCESS: state_d = DONE;
         DONE: begin
            state_d         = IDLE;
            done_d[owner_q] = 1'b1;
            err_d           = (decode_strobes(we_q, dev_q) == 3'b000);
            if (!we_q && dev_q == DEV_SWITCH) begin
               rdata_d = iSwitchData;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCpuClock or posedge iCpuReset) begin
      if (iCpuReset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         dev_q    <= '0;
         sub_q    <= '0;
         wdata_q  <= '0;
         gnt_q    <= '0;
         strobe_q <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         dev_q    <= dev_d;
         sub_q    <= sub_d;
         wdata_q  <= wdata_d;
         gnt_q    <= gnt_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.oGnt       = gnt_q;
   assign bus.oDone      = done_q;
   assign bus.oErr       = err_q;
   assign bus.oRdata     = rdata_q;
   assign oDoLedWrite    = strobe_q[0];
   assign oDoSwitchRead  = strobe_q[1];
   assign oDoTubeWrite   = strobe_q[2];
   assign oLightAddress  = sub_q;
   assign oSwitchAddress = sub_q;
   assign oTubeAddress   = sub_q;
   assign oLightData     = wdata_q;
   assign oTubeData      = wdata_q;
endmodule

// File: tb/tb_io_access_arbiter.sv
// Bench for io_access_arbiter: round-robin and fixed-priority instances driven by shared stimulus,
// checked each cycle against a transaction-level model plus directed literal expectations.
module tb_io_access_arbiter;
   localparam int DW = 16;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] req, we;
   logic [SW+1:0] a0, a1;
   logic [DW-1:0] wd0, wd1, sw_data;
   bit cmp_en = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_access_arbiter_if #(.DATA_W(DW), .SUB_W(SW)) bus0 ();
   io_access_arbiter_if #(.DATA_W(DW), .SUB_W(SW)) bus1 ();

   assign bus0.iReq = req;  assign bus0.iWe = we;
   assign bus0.iAddr0 = a0; assign bus0.iAddr1 = a1;
   assign bus0.iWdata0 = wd0; assign bus0.iWdata1 = wd1;
   assign bus1.iReq = req;  assign bus1.iWe = we;
   assign bus1.iAddr0 = a0; assign bus1.iAddr1 = a1;
   assign bus1.iWdata0 = wd0; assign bus1.iWdata1 = wd1;

   logic [1:0]    o_gnt[2], o_done[2];
   logic          o_err[2], o_led[2], o_sw[2], o_tube[2];
   logic [DW-1:0] o_rd[2], o_ld[2], o_td[2];
   logic [SW-1:0] o_la[2], o_sa[2], o_ta[2];

   assign o_gnt[0] = bus0.oGnt;  assign o_done[0] = bus0.oDone;
   assign o_err[0] = bus0.oErr;  assign o_rd[0]   = bus0.oRdata;
   assign o_gnt[1] = bus1.oGnt;  assign o_done[1] = bus1.oDone;
   assign o_err[1] = bus1.oErr;  assign o_rd[1]   = bus1.oRdata;

   io_access_arbiter #(.DATA_W(DW), .SUB_W(SW), .ARB_MODE(0)) dut0 (
      .iCpuClock(clk), .iCpuReset(rst), .bus(bus0),
      .oDoLedWrite(o_led[0]), .oLightAddress(o_la[0]), .oLightData(o_ld[0]),
      .oDoSwitchRead(o_sw[0]), .oSwitchAddress(o_sa[0]), .iSwitchData(sw_data),
      .oDoTubeWrite(o_tube[0]), .oTubeAddress(o_ta[0]), .oTubeData(o_td[0])
   );

   io_access_arbiter #(.DATA_W(DW), .SUB_W(SW), .ARB_MODE(1)) dut1 (
      .iCpuClock(clk), .iCpuReset(rst), .bus(bus1),
      .oDoLedWrite(o_led[1]), .oLightAddress(o_la[1]), .oLightData(o_ld[1]),
      .oDoSwitchRead(o_sw[1]), .oSwitchAddress(o_sa[1]), .iSwitchData(sw_data),
      .oDoTubeWrite(o_tube[1]), .oTubeAddress(o_ta[1]), .oTubeData(o_td[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Transaction-level model: age counts edges since the grant (-1 = no transaction).
   int            age[2];
   logic          last[2], t_own[2], t_we[2];
   logic [1:0]    t_dev[2];
   logic [1:0]    e_gnt[2], e_done[2];
   logic          e_err[2], e_led[2], e_sw[2], e_tube[2];
   logic [DW-1:0] e_rd[2], e_wd[2];
   logic [SW-1:0] e_sub[2];
   int            mw;
   logic [SW+1:0] ma;
   logic          legal;

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         e_gnt[k] = 2'b00; e_done[k] = 2'b00; e_err[k] = 1'b0; e_rd[k] = '0;
         e_led[k] = 1'b0;  e_sw[k] = 1'b0;    e_tube[k] = 1'b0;
         if (rst) begin
            age[k] = -1; last[k] = 1'b1; e_sub[k] = '0; e_wd[k] = '0;
         end else if (age[k] == 0) begin
            age[k] = 1;
         end else if (age[k] == 1) begin
            age[k]    = 2;
            e_done[k] = t_own[k] ? 2'b10 : 2'b01;
            legal     = t_we[k] ? (t_dev[k] == 2'd0 || t_dev[k] == 2'd2) : (t_dev[k] == 2'd1);
            e_err[k]  = !legal;
            e_rd[k]   = (legal && !t_we[k]) ? sw_data : '0;
         end else if (req != 2'b00) begin
            if (req == 2'b11) mw = (k == 1 || last[k]) ? 0 : 1;
            else              mw = req[1] ? 1 : 0;
            last[k]   = (mw == 1);
            ma        = (mw == 1) ? a1 : a0;
            t_own[k]  = (mw == 1);
            t_we[k]   = we[mw];
            t_dev[k]  = ma[3:2];
            e_sub[k]  = ma[1:0];
            e_wd[k]   = (mw == 1) ? wd1 : wd0;
            e_gnt[k]  = (mw == 1) ? 2'b10 : 2'b01;
            e_led[k]  = t_we[k] && t_dev[k] == 2'd0;
            e_tube[k] = t_we[k] && t_dev[k] == 2'd2;
            e_sw[k]   = !t_we[k] && t_dev[k] == 2'd1;
            age[k]    = 0;
         end else begin
            age[k] = -1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt%0d", k),   32'(o_gnt[k]),  32'(e_gnt[k]));
            chk($sformatf("done%0d", k),  32'(o_done[k]), 32'(e_done[k]));
            chk($sformatf("err%0d", k),   32'(o_err[k]),  32'(e_err[k]));
            chk($sformatf("rdata%0d", k), 32'(o_rd[k]),   32'(e_rd[k]));
            chk($sformatf("led%0d", k),   32'(o_led[k]),  32'(e_led[k]));
            chk($sformatf("swrd%0d", k),  32'(o_sw[k]),   32'(e_sw[k]));
            chk($sformatf("tube%0d", k),  32'(o_tube[k]), 32'(e_tube[k]));
            chk($sformatf("laddr%0d", k), 32'(o_la[k]),   32'(e_sub[k]));
            chk($sformatf("saddr%0d", k), 32'(o_sa[k]),   32'(e_sub[k]));
            chk($sformatf("taddr%0d", k), 32'(o_ta[k]),   32'(e_sub[k]));
            chk($sformatf("ldata%0d", k), 32'(o_ld[k]),   32'(e_wd[k]));
            chk($sformatf("tdata%0d", k), 32'(o_td[k]),   32'(e_wd[k]));
         end
      end
   end

   initial begin
      req = '0; we = '0; a0 = '0; a1 = '0; wd0 = '0; wd1 = '0; sw_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; cmp_en = 1'b1;
      chk("reset_gnt", 32'(bus0.oGnt), 0);
      chk("reset_done", 32'(bus0.oDone), 0);
      chk("reset_ldata", 32'(o_ld[0]), 0);
      @(posedge clk); #1;

      // CPU LED write
      req = 2'b01; we = 2'b01; a0 = 4'b0001; wd0 = 16'hA5A5;
      @(posedge clk); #1;
      chk("led_gnt", 32'(bus0.oGnt), 1);
      chk("led_strobe", 32'(o_led[0]), 1);
      chk("led_addr", 32'(o_la[0]), 1);
      chk("led_data", 32'(o_ld[0]), 32'h0000A5A5);
      req = 2'b00;
      @(posedge clk); #1;
      chk("led_strobe_off", 32'(o_led[0]), 0);
      @(posedge clk); #1;
      chk("led_done", 32'(bus0.oDone), 1);
      chk("led_err", 32'(bus0.oErr), 0);

      // Debug switch read
      req = 2'b10; we = 2'b00; a1 = 4'b0110; sw_data = 16'h1234;
      @(posedge clk); #1;
      chk("sw_gnt", 32'(bus0.oGnt), 2);
      chk("sw_strobe", 32'(o_sw[0]), 1);
      chk("sw_addr", 32'(o_sa[0]), 2);
      req = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      chk("sw_done", 32'(bus0.oDone), 2);
      chk("sw_rdata", 32'(bus0.oRdata), 32'h00001234);

      // Tie held continuously
      req = 2'b11; we = 2'b11; a0 = 4'b0000; a1 = 4'b1001; wd0 = 16'h1111; wd1 = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rr_gnt_%0d", i), 32'(bus0.oGnt), (i % 2 == 0) ? 1 : 2);
         chk($sformatf("fp_gnt_%0d", i), 32'(bus1.oGnt), 1);
         if (i == 3) req = 2'b00;
         @(posedge clk); @(posedge clk);
      end
      #1;

      // Illegal: write to switch, then read of device 3
      req = 2'b01; we = 2'b01; a0 = 4'b0100; wd0 = 16'hBEEF;
      @(posedge clk); #1;
      chk("ill1_strobes", 32'({o_led[0], o_sw[0], o_tube[0]}), 0);
      req = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      chk("ill1_done", 32'(bus0.oDone), 1);
      chk("ill1_err", 32'(bus0.oErr), 1);
      chk("ill1_rdata", 32'(bus0.oRdata), 0);
      req = 2'b01; we = 2'b00; a0 = 4'b1100; sw_data = 16'h5555;
      @(posedge clk); #1;
      chk("ill2_strobes", 32'({o_led[0], o_sw[0], o_tube[0]}), 0);
      req = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      chk("ill2_err", 32'(bus0.oErr), 1);
      chk("ill2_rdata", 32'(bus0.oRdata), 0);

      // Back-to-back tube write with request held
      req = 2'b01; we = 2'b01; a0 = 4'b1000; wd0 = 16'h00FF;
      @(posedge clk); #1;
      chk("tube_strobe", 32'(o_tube[0]), 1);
      chk("tube_data", 32'(o_td[0]), 32'h000000FF);
      @(posedge clk); @(posedge clk); #1;
      chk("tube_done", 32'(bus0.oDone), 1);
      @(posedge clk); #1;
      chk("tube_regnt", 32'(bus0.oGnt), 1);
      chk("tube_strobe2", 32'(o_tube[0]), 1);
      req = 2'b00;
      @(posedge clk); @(posedge clk); #1;

      // Randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 299) == 0);
         sw_data = 16'($urandom);
         if (!req[0] || bus0.oGnt[0]) begin
            req[0] = ($urandom_range(0, 2) == 0);
            we[0] = 1'($urandom_range(0, 1)); a0 = 4'($urandom); wd0 = 16'($urandom);
         end
         if (!req[1] || bus0.oGnt[1]) begin
            req[1] = ($urandom_range(0, 2) == 0);
            we[1] = 1'($urandom_range(0, 1)); a1 = 4'($urandom); wd1 = 16'($urandom);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; req = 2'b00;
      repeat (4) @(posedge clk);
      #1;

      // Reset in the middle of ACCESS
      req = 2'b01; we = 2'b01; a0 = 4'b0010; wd0 = 16'h7777;
      @(posedge clk); #1;
      chk("mid_gnt", 32'(bus0.oGnt), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_gnt", 32'(bus0.oGnt), 0);
      chk("mid_rst_led", 32'(o_led[0]), 0);
      chk("mid_rst_addr", 32'(o_la[0]), 0);
      chk("mid_rst_data", 32'(o_ld[0]), 0);
      req = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("mid_no_done_%0d", i), 32'(bus0.oDone), 0);
      end
      req = 2'b11;
      @(posedge clk); #1;
      chk("post_rst_tie", 32'(bus0.oGnt), 1);
      req = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
